// File: rtl/noc_pkg.sv
// noc_pkg: constants and types shared by the link-level NoC blocks.
//   DATA_SIZE  - default flit payload width
//   DATA_LSB   - bit position of the payload inside a connector port bundle
//   VALID_BIT  - bundle bit carrying the valid flag (default width)
//   READY_BIT  - bundle bit carrying the ready flag (default width)
//   flit_t     - payload type at the default width
//   cnt_width  - occupancy counter width for a FIFO of a given depth
package noc_pkg;

  localparam int unsigned DATA_SIZE = 37;
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned VALID_BIT = DATA_LSB + DATA_SIZE;
  localparam int unsigned READY_BIT = VALID_BIT + 1;

  typedef logic [DATA_SIZE-1:0] flit_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// link_fifo: synchronous FIFO used for both directions of a port_link.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (flushes all entries)
//   push, wdata  - write request and data; ignored while full
//   pop          - read request; ignored while empty
//   rdata        - head entry (valid while !empty)
//   full, empty  - occupancy flags
//   count        - current occupancy, 0..DEPTH
module link_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero while flushed.
  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/port_link.sv
// port_link: bidirectional flit buffer between a router crossbar and a link connector.
// Build option: define PORT_LINK_STATS_EN to enable the saturating flit counters.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   tx_data_i/tx_valid_i/tx_ready_o - local flit into the TX FIFO
//   rx_data_o/rx_valid_o/rx_ready_i - head of the RX FIFO towards the router
//   port_o                        - {ready, valid, data} bundle driven into the connector
//   port_i                        - {ready, valid, data} bundle received from the connector
//   tx_cnt_o, rx_cnt_o            - link transfers out / in (zero when stats disabled)
module port_link #(
  parameter int unsigned DATA_SIZE  = noc_pkg::DATA_SIZE,
  parameter int unsigned PORT_SIZE  = DATA_SIZE + 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [PORT_SIZE-1:0] port_o,
  input  logic [PORT_SIZE-1:0] port_i,
  output logic [15:0]          tx_cnt_o,
  output logic [15:0]          rx_cnt_o
);

  localparam int unsigned DataLsb  = noc_pkg::DATA_LSB;
  localparam int unsigned ValidIdx = DataLsb + DATA_SIZE;
  localparam int unsigned ReadyIdx = ValidIdx + 1;
  localparam int unsigned CntW     = noc_pkg::cnt_width(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] tx_head, rx_head;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic [CntW-1:0]      tx_count, rx_count, tx_count_d, rx_count_d;
  logic                 tx_ready_q, link_ready_q;
  logic                 tx_push, link_out, link_in, rx_pop;

  assign tx_push  = tx_valid_i & tx_ready_q;
  assign link_out = ~tx_empty & port_i[ReadyIdx];
  assign link_in  = port_i[ValidIdx] & link_ready_q;
  assign rx_pop   = ~rx_empty & rx_ready_i;

  link_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (tx_data_i),
    .pop   (link_out),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  link_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (link_in),
    .wdata (port_i[DataLsb +: DATA_SIZE]),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Both ready flags are registered from next-cycle occupancy, which keeps
  // them low through reset and forbids same-cycle full pass-through.
  always_comb begin
    tx_count_d = tx_count;
    if (tx_push && !link_out) begin
      tx_count_d = tx_count + CntW'(1);
    end else if (!tx_push && link_out) begin
      tx_count_d = tx_count - CntW'(1);
    end
    rx_count_d = rx_count;
    if (link_in && !rx_pop) begin
      rx_count_d = rx_count + CntW'(1);
    end else if (!link_in && rx_pop) begin
      rx_count_d = rx_count - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_q   <= 1'b0;
      link_ready_q <= 1'b0;
    end else begin
      tx_ready_q   <= (tx_count_d < CntW'(FIFO_DEPTH));
      link_ready_q <= (rx_count_d < CntW'(FIFO_DEPTH));
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_valid_o = ~rx_empty;
  assign rx_data_o  = rx_head;

  always_comb begin
    port_o                         = '0;
    port_o[DataLsb +: DATA_SIZE]   = tx_head;
    port_o[ValidIdx]               = ~tx_empty;
    port_o[ReadyIdx]               = link_ready_q;
  end

  // Full flags are redundant with the registered ready flags.
  logic unused_full;
  assign unused_full = tx_full ^ rx_full;

  if (PORT_SIZE > ReadyIdx + 1) begin : g_port_pad
    logic unused_port_hi;
    assign unused_port_hi = ^port_i[PORT_SIZE-1:ReadyIdx+1];
  end

`ifdef PORT_LINK_STATS_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (link_out && (tx_cnt_q != 16'hFFFF)) begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
      if (link_in && (rx_cnt_q != 16'hFFFF)) begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end
  end

  assign tx_cnt_o = tx_cnt_q;
  assign rx_cnt_o = rx_cnt_q;
`else
  assign tx_cnt_o = '0;
  assign rx_cnt_o = '0;
`endif

endmodule

// File: doc/port_link.md
PORT_LINK -- requirements
Module: port_link

Interface
REQ-001 Parameter DATA_SIZE, default 37: flit payload width in bits.
REQ-002 Parameter PORT_SIZE, default DATA_SIZE+2: width of one connector port bundle.
REQ-003 Parameter FIFO_DEPTH, default 4: entries per direction; power of two, at least 2.
REQ-004 Port bundle layout: [DATA_SIZE-1:0] data, [DATA_SIZE] valid, [DATA_SIZE+1] ready.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tx_data_i  input  DATA_SIZE  flit from router crossbar.
REQ-008 tx_valid_i  input  1  tx_data_i valid.
REQ-009 tx_ready_o  output  1  TX FIFO can accept a flit.
REQ-010 rx_data_o  output  DATA_SIZE  head flit of RX FIFO.
REQ-011 rx_valid_o  output  1  RX FIFO not empty.
REQ-012 rx_ready_i  input  1  router consumes rx_data_o.
REQ-013 port_o  output  PORT_SIZE  bundle driven into connector data_i slice.
REQ-014 port_i  input  PORT_SIZE  bundle received from connector data_o slice.
REQ-015 tx_cnt_o, rx_cnt_o  output  16 each  flit counters (see Configuration).

Function
REQ-016 Local push: TX FIFO writes tx_data_i when tx_valid_i and tx_ready_o are both high at a clock edge.
REQ-017 tx_ready_o is high exactly when the TX FIFO is not full; a pop in the same cycle does not raise it (no full-pass-through).
REQ-018 port_o.valid is high exactly when the TX FIFO is not empty, and port_o.data is the TX head entry; both come from flops, with no combinational path from any input.
REQ-019 Link transfer out: TX pop when port_o.valid and port_i.ready are both high at a clock edge.
REQ-020 Latency: a flit pushed at edge N is visible on port_o at edge N+1 at the earliest; there is no empty-FIFO bypass.
REQ-021 Link transfer in: RX FIFO writes port_i.data when port_i.valid and port_o.ready are both high at a clock edge.
REQ-022 port_o.ready is a flop loaded each edge with (next RX occupancy < FIFO_DEPTH), so it is never high while the RX FIFO is full.
REQ-023 Local pop: RX pop when rx_valid_o and rx_ready_i are both high at a clock edge.
REQ-024 Simultaneous push and pop on a non-empty, non-full FIFO keeps occupancy unchanged and preserves order.
REQ-025 Pointers wrap modulo FIFO_DEPTH; occupancy is a counter of width clog2(FIFO_DEPTH)+1.
REQ-026 A write attempted while a FIFO is full shall have no effect; a read attempted while a FIFO is empty shall have no effect.
REQ-027 Flit order is preserved end to end, with no loss and no duplication.

Reset
REQ-028 While rst_n is low: both FIFOs are empty; port_o is all zeros; tx_ready_o=0; rx_valid_o=0; counters are 0.
REQ-029 Asserting reset mid-transfer flushes all in-flight flits immediately, without waiting for a clock edge.
REQ-030 On the first clock edge after rst_n rises, port_o.ready becomes 1 and tx_ready_o becomes 1.

Configuration
REQ-031 Macro PORT_LINK_STATS_EN defined: tx_cnt_o increments on each link transfer out and rx_cnt_o on each link transfer in; both saturate at 16'hFFFF.
REQ-032 Macro PORT_LINK_STATS_EN undefined: tx_cnt_o and rx_cnt_o are constant 0 and no counter flops exist.

Structure
REQ-033 Shared package noc_pkg holds DATA_SIZE, the bundle bit-index constants (DATA_LSB, VALID_BIT, READY_BIT) and the flit typedef.
REQ-034 Both FIFOs are instances of one sub-module, link_fifo (parameters: width, depth; ports: push/pop/full/empty/count).

Verification
REQ-035 Reset release, then push 3 flits 0x01,0x02,0x03 with port_i.ready=1 -> port_o shows them on consecutive cycles starting 1 cycle after the first push; tx_cnt_o=3.
REQ-036 port_i.ready=0, push 5 flits with FIFO_DEPTH=4 -> tx_ready_o falls after the 4th flit; the 5th is held; release ready -> order 1..5 is preserved.
REQ-037 Drive port_i.valid=1 every cycle with rx_ready_i=0 -> exactly 4 flits are accepted, port_o.ready=0 from then on, and no overwrite occurs.
REQ-038 Full RX FIFO, rx_ready_i=1 and port_i.valid=1 together -> port_o.ready returns high 1 cycle after the first pop; occupancy never exceeds 4.
REQ-039 Two port_link instances looped through circulant_2 (NODES_NUM=4, S0=1, S1=2) -> a flit injected at node 0 port 0 emerges at node 1 port 3 unchanged.
REQ-040 Reset asserted with 2 flits in each FIFO -> port_o=0 and rx_valid_o=0 asynchronously; after release both FIFOs are empty; with PORT_LINK_STATS_EN undefined, counters read 0 throughout.
